// File: rtl/display_mux.sv
// Multiplexed 7-segment display: per-channel SW/CODE match flags, a button-selected
// single digit or a scanned display. Optional BTN debounce under DISPLAY_MUX_DEBOUNCE_EN.
module display_mux #(
  parameter int N_CH        = 4,
  parameter int SW_W        = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEB_CYC     = 10000
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_CH*SW_W-1:0]    SW,
  input  logic [N_CH*SW_W-1:0]    CODE,
  input  logic [$clog2(N_CH)-1:0] BTN,
  input  logic                    MODE,
  output logic [6:0]              SEG,
  output logic [N_CH-1:0]         AN,
  output logic [$clog2(N_CH)-1:0] LED,
  output logic [N_CH-1:0]         MATCH
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_CH - 1);

  if (N_CH < 2 || N_CH > 8 || SW_W < 1 || SW_W > 4 || REFRESH_DIV < 2 || DEB_CYC < 1)
  begin : g_param_check
    $error("display_mux: parameter out of range");
  end

  logic [SEL_W-1:0] btn_s1_q, btn_s2_q;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] led_q;
  logic [N_CH-1:0]  match_q, match_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_CH-1:0]  an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [SEL_W-1:0] cur;
  logic             accept;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0001100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

`ifdef DISPLAY_MUX_DEBOUNCE_EN
  // cnt_q counts consecutive sampling edges that saw cand_q; accept fires once on reaching DEB_CYC.
  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEB_CYC);
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (btn_s2_q != cand_q) begin
      cand_d = btn_s2_q;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q != CNT_FULL) begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
    accept = (cnt_d == CNT_FULL) && ((btn_s2_q != cand_q) || (cnt_q != CNT_FULL));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign accept = 1'b1;
`endif

  always_comb begin
    sel_d = sel_q;
    if (accept && (int'(btn_s2_q) < N_CH)) sel_d = btn_s2_q;
  end

  always_comb begin
    match_d = '0;
    for (int i = 0; i < N_CH; i++)
      match_d[i] = (SW[i*SW_W +: SW_W] == CODE[i*SW_W +: SW_W]);
  end

  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
    end
  end

  // Only a matched channel lights, so at most one anode is ever driven low.
  always_comb begin
    cur   = MODE ? idx_q : sel_q;
    an_d  = '1;
    seg_d = 7'b1111111;
    for (int i = 0; i < N_CH; i++) begin
      if (cur == SEL_W'(i) && match_q[i]) begin
        an_d[N_CH-1-i] = 1'b0;
        seg_d          = glyph(4'(SW[i*SW_W +: SW_W]));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sel_q    <= '0;
      led_q    <= '0;
      match_q  <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      an_q     <= '1;
      seg_q    <= 7'b1111111;
    end else begin
      btn_s1_q <= BTN;
      btn_s2_q <= btn_s1_q;
      sel_q    <= sel_d;
      led_q    <= sel_q;
      match_q  <= match_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign LED   = led_q;
  assign MATCH = match_q;

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux: stimulus queues {AN,SEG,LED,MATCH} expectations
// stamped with a cycle number; a negedge monitor pops and compares them.
module tb_display_mux;
  localparam int N_CH = 4, SW_W = 4, REFRESH_DIV = 4, DEB_CYC = 3;
  localparam int EW = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw, code;
  logic [1:0]  btn;
  logic        mode;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  led;
  logic [3:0]  match;

  display_mux #(
    .N_CH(N_CH), .SW_W(SW_W), .REFRESH_DIV(REFRESH_DIV), .DEB_CYC(DEB_CYC)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .SW(sw), .CODE(code), .BTN(btn), .MODE(mode),
    .SEG(seg), .AN(an), .LED(led), .MATCH(match)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            when_q[$];
  string         tag_q[$];
  int total = 0, bad = 0, base = 0;

  logic [3:0] an_slot  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] seg_slot [4] = '{7'b0000110, 7'b0100000, 7'b0000000, 7'b0001100};

  task automatic expect_at(input string tag, input int k, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic [1:0] e_led,
                           input logic [3:0] e_match);
    when_q.push_back(base + k);
    exp_q.push_back({e_an, e_seg, e_led, e_match});
    tag_q.push_back(tag);
  endtask

  task automatic wait_k(input int k);
    int target;
    target = base + k;
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (when_q.size() != 0 && when_q[0] <= cyc) begin
      int            w;
      logic [EW-1:0] e;
      string         t;
      w = when_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (w != cyc) begin
        bad++;
        $display("FAIL %s: checked at cycle %0d instead of %0d", t, cyc, w);
      end else if ({an, seg, led, match} !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d got an=%b seg=%b led=%0d match=%b want an=%b seg=%b led=%0d match=%b",
                 t, cyc, an, seg, led, match, e[16:13], e[12:6], e[5:4], e[3:0]);
      end
    end
  end

  // driver
  initial begin
    sw = 16'h9863; code = 16'h9863; btn = 2'd0; mode = 1'b0; rst_n = 1'b0;
    expect_at("reset_state", 2, 4'b1111, 7'b1111111, 2'd0, 4'b0000);
    wait_k(3);
    rst_n = 1'b1;
    base = cyc;

    for (int k = 3; k <= 9; k++)
      expect_at("mode0_sel0", k, 4'b0111, 7'b0000110, 2'd0, 4'b1111);

    wait_k(12);
    mode = 1'b1;
    for (int k = 13; k <= 32; k++)
      expect_at("scan_all", k, an_slot[((k-1)/4)%4], seg_slot[((k-1)/4)%4], 2'd0, 4'b1111);

    wait_k(32);
    code = 16'h0800;
    for (int k = 34; k <= 52; k++) begin
      if (((k-1)/4)%4 == 2) expect_at("scan_ch2", k, 4'b1101, 7'b0000000, 2'd0, 4'b0100);
      else                  expect_at("scan_ch2", k, 4'b1111, 7'b1111111, 2'd0, 4'b0100);
    end

    wait_k(52);
    code = 16'h9863;
    expect_at("pre_reset_idx2", 57, 4'b1101, 7'b0000000, 2'd0, 4'b1111);
    expect_at("async_reset", 58, 4'b1111, 7'b1111111, 2'd0, 4'b0000);
    expect_at("held_reset", 59, 4'b1111, 7'b1111111, 2'd0, 4'b0000);
    wait_k(58);
    rst_n = 1'b0;
    wait_k(60);
    rst_n = 1'b1;
    base = cyc;

    expect_at("restart_first", 1, 4'b1111, 7'b1111111, 2'd0, 4'b1111);
    for (int k = 2; k <= 8; k++)
      expect_at("restart_scan", k, an_slot[((k-1)/4)%4], seg_slot[((k-1)/4)%4], 2'd0, 4'b1111);

    wait_k(8);
    mode = 1'b0;
`ifdef DISPLAY_MUX_DEBOUNCE_EN
    for (int k = 10; k <= 21; k++)
      expect_at("bounce_hold", k, 4'b0111, 7'b0000110, 2'd0, 4'b1111);
    for (int k = 22; k <= 24; k++)
      expect_at("debounced", k, 4'b1101, 7'b0000000, 2'd2, 4'b1111);
    wait_k(10); btn = 2'd1;
    wait_k(12); btn = 2'd2;
    wait_k(14); btn = 2'd1;
    wait_k(16); btn = 2'd2;
`else
    for (int k = 10; k <= 13; k++)
      expect_at("btn_latency_pre", k, 4'b0111, 7'b0000110, 2'd0, 4'b1111);
    for (int k = 14; k <= 16; k++)
      expect_at("btn_latency_post", k, 4'b1110, 7'b0001100, 2'd3, 4'b1111);
    wait_k(10); btn = 2'd3;
`endif

    wait_k(30);
    if (when_q.size() != 0) begin
      $display("FAIL pending: %0d expectations never checked", when_q.size());
      total += when_q.size();
      bad   += when_q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of switch channels and display digits, range 2..8.
REQ-002 SHALL have parameter SW_W, default 4: switch bits per channel, range 1..4.
REQ-003 SHALL have parameter REFRESH_DIV, default 100000: CLK cycles each digit is lit during scan, minimum 2.
REQ-004 SHALL have parameter DEB_CYC, default 10000: CLK cycles a button value must be stable before acceptance, minimum 1.
REQ-005 SHALL have port CLK, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port SW, input, N_CH*SW_W: channel i occupies SW[i*SW_W +: SW_W].
REQ-008 SHALL have port CODE, input, N_CH*SW_W: expected value per channel, same packing; quasi-static.
REQ-009 SHALL have port BTN, input, SEL_W=$clog2(N_CH): requested channel, asynchronous.
REQ-010 SHALL have port MODE, input, 1: 0 = show selected channel only; 1 = scan all channels.
REQ-011 SHALL have port SEG, output, 7: active-low segments, SEG[6]=a .. SEG[0]=g.
REQ-012 SHALL have port AN, output, N_CH: active-low anodes; channel i drives AN[N_CH-1-i].
REQ-013 SHALL have port LED, output, SEL_W: currently accepted selection.
REQ-014 SHALL have port MATCH, output, N_CH: registered per-channel flag, bit i = (SW channel i == CODE channel i).

Function
REQ-015 SHALL pass BTN through a 2-flop synchroniser before any use.
REQ-016 SHALL, with debounce compiled in, load selection sel from synchronised BTN after it holds one value for DEB_CYC consecutive cycles; any change restarts the count.
REQ-017 SHALL ignore accepted BTN values >= N_CH; sel holds its previous value.
REQ-018 SHALL drive LED = sel, registered, updating the cycle after sel changes.
REQ-019 SHALL register MATCH every cycle: one cycle latency from SW/CODE.
REQ-020 SHALL run refresh counter 0..REFRESH_DIV-1 continuously; on terminal count it wraps to 0 and scan index idx advances, wrapping N_CH-1 -> 0.
REQ-021 SHALL, MODE=0, drive AN low for channel sel only when MATCH[sel]=1, else AN all ones; no scanning.
REQ-022 SHALL, MODE=1, drive AN low for channel idx only when MATCH[idx]=1, else AN all ones for that slot.
REQ-023 SHALL, when a digit is lit, drive SEG with the hex glyph of that channel's SW zero-extended to 4 bits (0-F; e.g. 3=0000110, 6=0100000, 8=0000000, 9=0001100); otherwise SEG=1111111.
REQ-024 SHALL register AN and SEG: one cycle after idx/sel/MATCH/MODE change; never more than one AN bit low.
REQ-025 SHALL apply a MODE change on the next cycle without resetting idx or the refresh counter.

Reset
REQ-026 SHALL, on RST_N low, asynchronously clear: SEG=1111111, AN all ones, LED=0, MATCH=0, sel=0, idx=0, refresh and debounce counters=0, synchroniser flops=0.
REQ-027 SHALL release reset synchronously; first scan slot is idx=0 for a full REFRESH_DIV cycles.
REQ-028 SHALL, on reset mid-debounce, discard the pending BTN value.

Configuration
REQ-029 SHALL honour macro DISPLAY_MUX_DEBOUNCE_EN: defined -> REQ-016 debounce; undefined -> sel loads synchronised BTN every cycle (BTN-to-LED latency 4 cycles) and the debounce counter is not built.

Verification (N_CH=4, SW_W=4, REFRESH_DIV=4, DEB_CYC=3, macro defined unless stated)
REQ-030 SHALL cover: MODE=0, BTN=0, SW0=CODE0=3 -> after settle LED=0, AN=0111, SEG=0000110 steady.
REQ-031 SHALL cover: MODE=1, all channels matched with values 3,6,8,9 -> AN cycles 0111,1011,1101,1110 each 4 cycles, SEG 0000110,0100000,0000000,0001100.
REQ-032 SHALL cover: MODE=1, only channel 2 matched -> AN=1101 for 4 of every 16 cycles, else AN=1111 and SEG=1111111.
REQ-033 SHALL cover: BTN toggles 1->2->1 every 2 cycles then holds 2 -> LED stays 0 during bounce, becomes 2 after 3 stable synchronised cycles.
REQ-034 SHALL cover: RST_N low mid-scan at idx=2 -> outputs at reset values immediately without clock; scan restarts at idx=0.
REQ-035 SHALL cover: macro undefined, BTN 0->3 -> LED=3 exactly 4 cycles later.
